mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store engine for the MIPS32 pipeline. It takes the effective address computed in EX from the ID-stage operands, plus the opcode and rt store data, and drives a word-wide data-RAM bus with a ready handshake. It stalls the pipeline until the access completes, returns sign- or zero-extended load data, and flags misaligned and timed-out accesses. Supported ops are LB, LBU, LH, LHU, LW, SB, SH and SW. Byte order is little-endian.

## Interface
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without ram_ready before bus_error (range 1..1023).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  memory-stage instruction valid; held stable by upstream while stall_req=1.
- op  in  6  opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- addr  in  32  effective byte address (operand_1 + operand_2).
- store_data  in  32  rt value for stores.
- stall_req  out  1  holds the pipeline (combinational).
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result, valid while done=1.
- misaligned  out  1  pulse with done: address not aligned to access size.
- bus_error  out  1  pulse with done: timeout.
- ram_en  out  1  bus request.
- ram_write_en  out  4  byte enables; 0000 for loads.
- ram_addr  out  32  word address {addr[31:2], 2'b00}.
- ram_write_data  out  32  lane-replicated store data.
- ram_ready  in  1  access complete this cycle.
- ram_read_data  in  32  read word, sampled when ram_ready=1.

## Operation
- FSM states: IDLE, BUSY, RESP.
- Accept condition: state=IDLE, req_valid=1, op is one of the eight memory opcodes. Other opcodes are ignored and do not assert stall_req.
- Alignment rule: LH/LHU/SH require addr[0]=0. LW/SW require addr[1:0]=0. Bytes are always aligned.
- IDLE, aligned accept: latch op, addr[1:0], bus fields and store data, then go to BUSY.
- IDLE, misaligned accept: no bus access; go to RESP with misaligned=1 and load_data=0.
- BUSY:
  - Bus outputs come from registers and are held constant.
  - ram_ready=1: capture read data, go to RESP.
  - Otherwise the timeout counter increments. If it reaches TIMEOUT_CYCLES, deassert ram_en and go to RESP with bus_error=1 and load_data=0.
- RESP:
  - done=1 for one cycle; ram_en=0; stall_req=0.
  - Always returns to IDLE.
  - req_valid is ignored, so the still-presented instruction is not re-issued.
- Byte enables:
  - SB: 0001 shifted left by addr[1:0].
  - SH: 0011 if addr[1]=0, else 1100.
  - SW: 1111.
- Store data: SB {4{store_data[7:0]}}, SH {2{store_data[15:0]}}, SW store_data.
- Load extraction:
  - Byte lane = addr[1:0], i.e. bits 8*k+7:8*k.
  - Halfword = bits 15:0 if addr[1]=0, else bits 31:16.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- stall_req = (IDLE and accept condition) or BUSY.
- Reset (any state, including mid-BUSY):
  - state=IDLE; ram_en=0 immediately.
  - All outputs 0, counter 0.
  - The interrupted access produces no done.

## Timing
- Zero-wait access (ram_ready high during the first BUSY cycle):
  - Accept in cycle T; BUSY in T+1; RESP/done in T+2.
  - stall_req is high in T and T+1.
- k wait cycles: done in T+2+k; stall_req high for 2+k cycles.
- Misaligned: done/misaligned in T+1; stall_req high in T only.
- Timeout: bus_error/done in T+1+TIMEOUT_CYCLES; ram_en high for exactly TIMEOUT_CYCLES cycles.
- ram_ready is ignored outside BUSY.
- Back-to-back: the next instruction can be accepted in the cycle after RESP.

## Test plan
- LB addr 0x0000_0003, RAM word 0x80FF_1234, zero wait:
  - ram_addr 0x0, wen 0000.
  - done at T+2, load_data 0xFFFF_FF80.
  - Repeat as LBU -> 0x0000_0080.
- SH addr 0x0000_0102, store_data 0x1234_ABCD:
  - ram_addr 0x100, wen 1100, wdata 0xABCD_ABCD.
  - done at T+2, no misaligned.
- LW addr 0x40 with ram_ready delayed 3 cycles, read 0xDEAD_BEEF:
  - stall_req high 5 cycles, done at T+5, load_data 0xDEAD_BEEF.
- LW addr 0x0000_0101 and LHU addr 0x0000_0003:
  - ram_en never asserted.
  - misaligned=1 with done at T+1, load_data 0.
- TIMEOUT_CYCLES=4, SW, ram_ready held 0:
  - ram_en high 4 cycles, bus_error and done at T+5.
  - Next request accepted at T+6.
- Reset asserted in the second BUSY cycle:
  - ram_en drops without waiting for a clock, no done.
  - After release, with a valid LB still presented: accepted on the first clock, stall_req high.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS32 memory-stage load/store engine with ready-handshake RAM bus
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic        ram_ready,
  input  logic [31:0] ram_read_data
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_next;
  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  wen_q;
  logic [31:0] wdata_q;
  logic [9:0]  timer_q;
  logic [31:0] ldata_q;
  logic        mis_q;
  logic        err_q;

  logic        is_mem;
  logic        aligned;
  logic [3:0]  wen_d;
  logic [31:0] wdata_d;
  logic        accept;
  logic        timeout_hit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    is_mem  = 1'b1;
    aligned = 1'b1;
    wen_d   = 4'b0000;
    wdata_d = 32'h0;
    case (op)
      OP_LB, OP_LBU: aligned = 1'b1;
      OP_LH, OP_LHU: aligned = ~addr[0];
      OP_LW:         aligned = (addr[1:0] == 2'b00);
      OP_SB: begin
        wen_d   = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      OP_SH: begin
        aligned = ~addr[0];
        wen_d   = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      OP_SW: begin
        aligned = (addr[1:0] == 2'b00);
        wen_d   = 4'b1111;
        wdata_d = store_data;
      end
      default: is_mem = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && req_valid && is_mem;
  // timer_q counts misses already seen, so this miss is the TIMEOUT_CYCLES-th one
  assign timeout_hit = (timer_q == 10'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_req  = 1'b1;
          state_next = aligned ? BUSY : RESP;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (ram_ready || timeout_hit) state_next = RESP;
      end
      RESP: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = ram_read_data[7:0];
      2'd1:    byte_sel = ram_read_data[15:8];
      2'd2:    byte_sel = ram_read_data[23:16];
      default: byte_sel = ram_read_data[31:24];
    endcase
    half_sel = off_q[1] ? ram_read_data[31:16] : ram_read_data[15:0];
    case (op_q)
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h0, byte_sel};
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0, half_sel};
      OP_LW:   load_ext = ram_read_data;
      default: load_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 6'h0;
      off_q   <= 2'b00;
      addr_q  <= 32'h0;
      wen_q   <= 4'b0000;
      wdata_q <= 32'h0;
      timer_q <= 10'd0;
      ldata_q <= 32'h0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= op;
      off_q   <= addr[1:0];
      addr_q  <= {addr[31:2], 2'b00};
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      timer_q <= 10'd0;
      ldata_q <= 32'h0;
      mis_q   <= ~aligned;
      err_q   <= 1'b0;
    end else if (state == BUSY) begin
      if (ram_ready) begin
        ldata_q <= load_ext;
      end else begin
        timer_q <= timer_q + 10'd1;
        if (timeout_hit) err_q <= 1'b1;
      end
    end
  end

  // Bus fields only leave the block while BUSY; elsewhere the bus reads as idle zeros
  assign ram_en         = (state == BUSY);
  assign ram_addr       = ram_en ? addr_q : 32'h0;
  assign ram_write_en   = ram_en ? wen_q : 4'b0000;
  assign ram_write_data = ram_en ? wdata_q : 32'h0;

  assign load_data  = done ? ldata_q : 32'h0;
  assign misaligned = done & mis_q;
  assign bus_error  = done & err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a directed vector list
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall_req;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_ready;
  logic [31:0] ram_read_data;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .op(op), .addr(addr),
    .store_data(store_data), .stall_req(stall_req), .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_error(bus_error), .ram_en(ram_en),
    .ram_write_en(ram_write_en), .ram_addr(ram_addr), .ram_write_data(ram_write_data),
    .ram_ready(ram_ready), .ram_read_data(ram_read_data)
  );

  typedef struct {
    logic [31:0] load;
    logic        mis;
    logic        err;
    int          done_cyc;
    int          stall_n;
    int          en_n;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic        chk_wdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int ram_wait = 0;
  logic [31:0] ram_word = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  int mon_stall = 0;
  int mon_en    = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_stall = 0;
      mon_en    = 0;
    end else begin
      if (stall_req) mon_stall++;
      if (ram_en) mon_en++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("load_data", load_data, e.load);
          check("misaligned", {31'h0, misaligned}, {31'h0, e.mis});
          check("bus_error", {31'h0, bus_error}, {31'h0, e.err});
          check("done_cycle", cyc, e.done_cyc);
          check("stall_cycles", mon_stall, e.stall_n);
          check("ram_en_cycles", mon_en, e.en_n);
        end
        mon_stall = 0;
        mon_en    = 0;
      end
    end
  end

  // RAM model: checks bus fields on the first ram_en cycle, then answers after ram_wait cycles
  bit rsp_active = 0;
  int rsp_cnt = 0;
  always @(negedge clk) begin
    bus_t b;
    if (!rst_n || !ram_en) begin
      rsp_active = 0;
      ram_ready  = 1'b0;
    end else begin
      if (!rsp_active) begin
        rsp_active = 1;
        rsp_cnt    = ram_wait;
        if (bus_q.size() == 0) begin
          check("unexpected_ram_en", 32'd1, 32'd0);
        end else begin
          b = bus_q.pop_front();
          check("ram_addr", ram_addr, b.a);
          check("ram_write_en", {28'h0, ram_write_en}, {28'h0, b.wen});
          if (b.chk_wdata) check("ram_write_data", ram_write_data, b.wdata);
        end
      end
      if (rsp_cnt == 0) begin
        ram_ready     = 1'b1;
        ram_read_data = ram_word;
      end else begin
        ram_ready = 1'b0;
        rsp_cnt--;
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic gap();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] word, input int waits,
                       input logic [31:0] e_load, input logic e_mis, input logic e_err,
                       input int lat, input int stall_n, input int en_n,
                       input logic has_bus, input logic [31:0] b_addr, input logic [3:0] b_wen,
                       input logic [31:0] b_wdata, input logic chk_wd);
    exp_t e;
    bus_t b;
    @(posedge clk);
    #1;
    e.load = e_load; e.mis = e_mis; e.err = e_err;
    e.done_cyc = cyc + lat; e.stall_n = stall_n; e.en_n = en_n;
    exp_q.push_back(e);
    if (has_bus) begin
      b.a = b_addr; b.wen = b_wen; b.wdata = b_wdata; b.chk_wdata = chk_wd;
      bus_q.push_back(b);
    end
    ram_word  = word;
    ram_wait  = waits;
    req_valid = 1'b1;
    op        = o;
    addr      = a;
    store_data = sd;
    wait_done();
  endtask

  initial begin
    bus_t b;
    exp_t e;
    rst_n = 1'b0;
    req_valid = 1'b0;
    op = 6'h0;
    addr = 32'h0;
    store_data = 32'h0;
    ram_ready = 1'b0;
    ram_read_data = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_stall_req", {31'h0, stall_req}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_ram_en", {31'h0, ram_en}, 32'h0);
    check("rst_ram_write_en", {28'h0, ram_write_en}, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_write_data", ram_write_data, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    check("rst_bus_error", {31'h0, bus_error}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LB / LBU of top byte of 0x80FF_1234
    issue(6'h20, 32'h3, 32'h0, 32'h80FF_1234, 0, 32'hFFFF_FF80, 0, 0, 2, 2, 1, 1, 32'h0, 4'b0000, 32'h0, 0);
    gap();
    issue(6'h24, 32'h3, 32'h0, 32'h80FF_1234, 0, 32'h0000_0080, 0, 0, 2, 2, 1, 1, 32'h0, 4'b0000, 32'h0, 0);
    gap();
    issue(6'h29, 32'h102, 32'h1234_ABCD, 32'h0, 0, 32'h0, 0, 0, 2, 2, 1, 1, 32'h100, 4'b1100, 32'hABCD_ABCD, 1);
    gap();
    issue(6'h23, 32'h40, 32'h0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 0, 0, 5, 5, 4, 1, 32'h40, 4'b0000, 32'h0, 0);
    gap();
    issue(6'h23, 32'h101, 32'h0, 32'h0, 0, 32'h0, 1, 0, 1, 1, 0, 0, 32'h0, 4'b0000, 32'h0, 0);
    gap();
    issue(6'h25, 32'h3, 32'h0, 32'h0, 0, 32'h0, 1, 0, 1, 1, 0, 0, 32'h0, 4'b0000, 32'h0, 0);
    gap();
    // SW never answered: timeout, then a back-to-back LH accepted the cycle after RESP
    issue(6'h2B, 32'h200, 32'hCAFE_F00D, 32'h0, 1000, 32'h0, 0, 1, 5, 5, 4, 1, 32'h200, 4'b1111, 32'hCAFE_F00D, 1);
    issue(6'h21, 32'h6, 32'h0, 32'h9ABC_0000, 0, 32'hFFFF_9ABC, 0, 0, 2, 2, 1, 1, 32'h4, 4'b0000, 32'h0, 0);
    gap();
    issue(6'h28, 32'h1, 32'h1234_5678, 32'h0, 1, 32'h0, 0, 0, 3, 3, 2, 1, 32'h0, 4'b0010, 32'h7878_7878, 1);
    gap();
    issue(6'h25, 32'h2, 32'h0, 32'h8765_4321, 0, 32'h0000_8765, 0, 0, 2, 2, 1, 1, 32'h0, 4'b0000, 32'h0, 0);
    gap();

    // Non-memory opcode is ignored
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    op = 6'h00;
    addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nonmem_stall_req", {31'h0, stall_req}, 32'h0);
      check("nonmem_ram_en", {31'h0, ram_en}, 32'h0);
    end
    gap();

    // Reset in the second BUSY cycle of an LW
    @(posedge clk);
    #1;
    b.a = 32'h300; b.wen = 4'b0000; b.wdata = 32'h0; b.chk_wdata = 0;
    bus_q.push_back(b);
    ram_wait = 1000;
    req_valid = 1'b1;
    op = 6'h23;
    addr = 32'h300;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_ram_en_async", {31'h0, ram_en}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    op = 6'h20;
    addr = 32'h5;
    ram_word = 32'h0000_7F00;
    ram_wait = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    b.a = 32'h4; b.wen = 4'b0000; b.wdata = 32'h0; b.chk_wdata = 0;
    bus_q.push_back(b);
    e.load = 32'h0000_007F; e.mis = 0; e.err = 0;
    e.done_cyc = cyc + 2; e.stall_n = 2; e.en_n = 1;
    exp_q.push_back(e);
    rst_n = 1'b1;
    #1;
    check("post_reset_stall_req", {31'h0, stall_req}, 32'h1);
    wait_done();
    gap();
    repeat (3) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 32'h0);
    check("bus_queue_drained", bus_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
